// File: rtl/mss_ccc_divgen_if.sv
// ============================================================================
//  Module   : mss_ccc_divgen_if
//  Purpose  : Configuration and clock-output bundle of the divider generator.
//             The master side writes channel configurations; the slave side
//             (the divider block) returns status, strobes and divided clocks.
//  Signals  : CFG_WE      - configuration write strobe
//             CFG_CH      - target channel index
//             CFG_DIV     - divide code D (channel period D+1 cycles)
//             CFG_BYPASS  - bypass request for the target channel
//             CFG_ERR     - one-cycle pulse for a rejected write
//             CFG_BUSY    - per-channel "configuration pending" flag
//             CLKEN       - per-channel one-cycle enable strobe
//             CLKOUT      - per-channel registered divided clock
//             LOCK        - all channels stable for LOCK_CYC cycles
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mss_ccc_divgen_if #(
  parameter int NCH  = 3,
  parameter int DIVW = 5
);
  logic            CFG_WE;
  logic [1:0]      CFG_CH;
  logic [DIVW-1:0] CFG_DIV;
  logic            CFG_BYPASS;
  logic            CFG_ERR;
  logic [NCH-1:0]  CFG_BUSY;
  logic [NCH-1:0]  CLKEN;
  logic [NCH-1:0]  CLKOUT;
  logic            LOCK;

  modport master (
    output CFG_WE, CFG_CH, CFG_DIV, CFG_BYPASS,
    input  CFG_ERR, CFG_BUSY, CLKEN, CLKOUT, LOCK
  );

  modport slave (
    input  CFG_WE, CFG_CH, CFG_DIV, CFG_BYPASS,
    output CFG_ERR, CFG_BUSY, CLKEN, CLKOUT, LOCK
  );
endinterface

`default_nettype wire

// File: rtl/mss_ccc_divgen.sv
// ============================================================================
//  Module   : mss_ccc_divgen
//  Purpose  : Multi-channel programmable clock-enable / divided-clock
//             generator with glitch-free reconfiguration and a lock monitor.
//  Ports    : CLKA   - source clock, all logic on its rising edge
//             RESETN - asynchronous active-low reset
//             bus    - mss_ccc_divgen_if.slave (config in, status/clocks out)
//  Params   : NCH      - number of channels (1..4)
//             DIVW     - divide-code width
//             DEF_DIV  - divide code loaded at reset
//             LOCK_CYC - stable cycles required before LOCK (2..65535)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mss_ccc_divgen #(
  parameter int NCH      = 3,
  parameter int DIVW     = 5,
  parameter int DEF_DIV  = 3,
  parameter int LOCK_CYC = 64
) (
  input wire              CLKA,
  input wire              RESETN,
  mss_ccc_divgen_if.slave bus
);

  localparam logic [15:0]     c_lock_last = 16'(LOCK_CYC - 1);
  localparam logic [DIVW-1:0] c_def_div   = DIVW'(DEF_DIV);

  logic            w_ch_ok;
  logic            w_acc;
  logic            w_quiet;
  logic [NCH-1:0]  w_busy;
  logic [NCH-1:0]  w_clken;
  logic [NCH-1:0]  w_clkout;

  // Channel indices beyond NCH are rejected rather than aliased.
  assign w_ch_ok = (int'(bus.CFG_CH) < NCH);
  assign w_acc   = bus.CFG_WE && w_ch_ok;

  // --------------------------------------------------------------------------
  // Divider channels
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DIVW-1:0] r_act_div;
    logic            r_act_byp;
    logic [DIVW-1:0] r_pend_div;
    logic            r_pend_byp;
    logic            r_pend_vld;
    logic [DIVW-1:0] r_cnt;
    logic            r_clken;
    logic            r_clkout;
    logic            w_sel;
    logic            w_tc;
    logic            w_apply;

    assign w_sel   = w_acc && (bus.CFG_CH == 2'(gi));
    assign w_tc    = !r_act_byp && (r_cnt == '0);
    // New settings only take effect on a period boundary so the output
    // never produces a runt pulse; in bypass every cycle is a boundary.
    assign w_apply = r_pend_vld && (r_act_byp || w_tc);

    always_ff @(posedge CLKA or negedge RESETN) begin
      if (!RESETN) begin
        r_act_div  <= c_def_div;
        r_act_byp  <= 1'b0;
        r_pend_div <= '0;
        r_pend_byp <= 1'b0;
        r_pend_vld <= 1'b0;
        r_cnt      <= c_def_div;
        r_clken    <= 1'b0;
        r_clkout   <= 1'b0;
      end else begin
        if (r_act_byp || w_tc) begin
          r_clken  <= 1'b1;
          r_clkout <= ~r_clkout;
        end else begin
          r_clken  <= 1'b0;
        end

        if (w_apply) begin
          r_act_div <= r_pend_div;
          r_act_byp <= r_pend_byp;
          r_cnt     <= r_pend_byp ? '0 : r_pend_div;
        end else if (r_act_byp) begin
          r_cnt <= '0;
        end else if (w_tc) begin
          r_cnt <= r_act_div;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end

        // A write colliding with an apply wins, so the slot stays valid.
        if (w_sel) begin
          r_pend_div <= bus.CFG_DIV;
          r_pend_byp <= bus.CFG_BYPASS;
          r_pend_vld <= 1'b1;
        end else if (w_apply) begin
          r_pend_vld <= 1'b0;
        end
      end
    end

    assign w_busy[gi]   = r_pend_vld;
    assign w_clken[gi]  = r_clken;
    assign w_clkout[gi] = r_clkout;
  end

  // --------------------------------------------------------------------------
  // Lock monitor and error pulse
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_COUNT  = 2'd1,
    S_LOCKED = 2'd2
  } lock_st_t;

  lock_st_t    r_state;
  logic [15:0] r_stable;
  logic        r_lock;
  logic        r_err;

  assign w_quiet = (w_busy == '0) && !w_acc;

  always_ff @(posedge CLKA or negedge RESETN) begin
    if (!RESETN) begin
      r_state  <= S_WAIT;
      r_stable <= '0;
      r_lock   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= bus.CFG_WE && !w_ch_ok;
      case (r_state)
        S_WAIT: begin
          r_state  <= S_COUNT;
          r_stable <= '0;
          r_lock   <= 1'b0;
        end
        S_COUNT: begin
          if (!w_quiet) begin
            r_stable <= '0;
          end else if (r_stable == c_lock_last) begin
            // LOCK_CYC consecutive quiet cycles seen (0..LOCK_CYC-1).
            r_state  <= S_LOCKED;
            r_stable <= '0;
            r_lock   <= 1'b1;
          end else begin
            r_stable <= r_stable + 16'd1;
          end
        end
        S_LOCKED: begin
          if (w_acc) begin
            r_state  <= S_COUNT;
            r_stable <= '0;
            r_lock   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_WAIT;
          r_stable <= '0;
          r_lock   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CFG_ERR  = r_err;
  assign bus.CFG_BUSY = w_busy;
  assign bus.CLKEN    = w_clken;
  assign bus.CLKOUT   = w_clkout;
  assign bus.LOCK     = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_mss_ccc_divgen.sv
// ============================================================================
//  Module   : tb_mss_ccc_divgen
//  Purpose  : Self-checking bench for mss_ccc_divgen. A cycle-level model
//             (phase since last reload, pending slot, run length of quiet
//             cycles) predicts every output each cycle; directed sequences
//             add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mss_ccc_divgen;

  localparam int NCH      = 3;
  localparam int DIVW     = 5;
  localparam int DEF_DIV  = 3;
  localparam int LOCK_CYC = 64;

  logic CLKA   = 1'b0;
  logic RESETN = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mss_ccc_divgen_if #(.NCH(NCH), .DIVW(DIVW)) bus ();

  mss_ccc_divgen #(
    .NCH(NCH), .DIVW(DIVW), .DEF_DIV(DEF_DIV), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .CLKA  (CLKA),
    .RESETN(RESETN),
    .bus   (bus)
  );

  always #5 CLKA = ~CLKA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int m_div   [NCH];
  int m_phase [NCH];   // cycles since the last period boundary
  int m_pdiv  [NCH];
  bit m_byp   [NCH];
  bit m_pbyp  [NCH];
  bit m_pv    [NCH];
  bit m_en    [NCH];
  bit m_out   [NCH];
  bit m_err, m_started, m_locked;
  int m_run;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEF_DIV; m_phase[i] = 0; m_pdiv[i] = 0;
      m_byp[i] = 0; m_pbyp[i] = 0; m_pv[i] = 0; m_en[i] = 0; m_out[i] = 0;
    end
    m_err = 0; m_started = 0; m_locked = 0; m_run = 0;
  endfunction

  function automatic void model_step(input bit we, input int ch, input int dv, input bit bp);
    bit acc, anybusy, tc, ap;
    acc     = we && (ch < NCH);
    anybusy = 0;
    for (int i = 0; i < NCH; i++) anybusy |= m_pv[i];
    m_err = we && (ch >= NCH);
    if (!m_started) begin
      m_started = 1;
    end else if (acc) begin
      m_locked = 0; m_run = 0;
    end else if (!m_locked) begin
      if (!anybusy) begin
        m_run++;
        if (m_run == LOCK_CYC) begin m_locked = 1; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      tc = !m_byp[i] && (m_phase[i] == m_div[i]);
      ap = m_pv[i] && (m_byp[i] || tc);
      if (m_byp[i] || tc) begin
        m_en[i] = 1; m_out[i] = !m_out[i]; m_phase[i] = 0;
      end else begin
        m_en[i] = 0; m_phase[i]++;
      end
      if (ap) begin m_div[i] = m_pdiv[i]; m_byp[i] = m_pbyp[i]; m_phase[i] = 0; end
      if (acc && ch == i) begin m_pdiv[i] = dv; m_pbyp[i] = bp; m_pv[i] = 1; end
      else if (ap) m_pv[i] = 0;
    end
  endfunction

  // Single compare process: advance the model on every edge, check #1 later.
  initial begin
    logic [NCH-1:0] e_en, e_out, e_busy;
    model_reset();
    forever begin
      @(posedge CLKA or negedge RESETN);
      if (!RESETN) model_reset();
      else model_step(bus.CFG_WE, int'(bus.CFG_CH), int'(bus.CFG_DIV), bus.CFG_BYPASS);
      #1;
      for (int i = 0; i < NCH; i++) begin
        e_en[i] = m_en[i]; e_out[i] = m_out[i]; e_busy[i] = m_pv[i];
      end
      chk("model_clken",  bus.CLKEN,    e_en);
      chk("model_clkout", bus.CLKOUT,   e_out);
      chk("model_busy",   bus.CFG_BUSY, e_busy);
      chk("model_err",    bus.CFG_ERR,  m_err);
      chk("model_lock",   bus.LOCK,     m_locked);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLKA);
  endtask

  task automatic wr(input int ch, input int dv, input bit bp);
    bus.CFG_WE = 1'b1; bus.CFG_CH = 2'(ch); bus.CFG_DIV = DIVW'(dv); bus.CFG_BYPASS = bp;
    @(negedge CLKA);
    bus.CFG_WE = 1'b0;
  endtask

  function automatic bit cond(input int kind, input int idx);
    case (kind)
      0:       return bus.CFG_BUSY[idx] == 1'b0;
      1:       return bus.CLKEN[idx] == 1'b1;
      default: return bus.LOCK == 1'b1;
    endcase
  endfunction

  // Bounded wait; n returns the number of cycles waited.
  task automatic wait_for(input string name, input int kind, input int idx,
                          input int max, output int n);
    n = 0;
    while (!cond(kind, idx) && n < max) begin
      tick(1);
      n++;
    end
    if (!cond(kind, idx)) begin
      checks++; failures++;
      $display("FAIL timeout_%s: condition not met after %0d cycles", name, max);
    end
  endtask

  initial begin
    int n;
    bus.CFG_WE = 1'b0; bus.CFG_CH = 2'd0; bus.CFG_DIV = '0; bus.CFG_BYPASS = 1'b0;
    tick(2);
    chk("rst_clken",  bus.CLKEN,    3'b000);
    chk("rst_clkout", bus.CLKOUT,   3'b000);
    chk("rst_busy",   bus.CFG_BUSY, 3'b000);
    chk("rst_err",    bus.CFG_ERR,  1'b0);
    chk("rst_lock",   bus.LOCK,     1'b0);

    // Defaults: strobe every 4 cycles, CLKOUT period 8, LOCK at cycle 65.
    RESETN = 1'b1;
    tick(3); chk("en_c3",  bus.CLKEN,  3'b000);
    tick(1); chk("en_c4",  bus.CLKEN,  3'b111);
             chk("out_c4", bus.CLKOUT, 3'b111);
    tick(1); chk("en_c5",  bus.CLKEN,  3'b000);
    tick(3); chk("en_c8",  bus.CLKEN,  3'b111);
             chk("out_c8", bus.CLKOUT, 3'b000);
    tick(56); chk("lock_c64", bus.LOCK, 1'b0);
    tick(1);  chk("lock_c65", bus.LOCK, 1'b1);

    // Rejected write: error pulse only.
    wr(3, 5, 1'b0);
    chk("err_pulse",    bus.CFG_ERR,  1'b1);
    chk("err_nobusy",   bus.CFG_BUSY, 3'b000);
    chk("err_lock",     bus.LOCK,     1'b1);
    tick(1);
    chk("err_gone",     bus.CFG_ERR,  1'b0);
    chk("err_lock2",    bus.LOCK,     1'b1);

    // Reconfigure ch1 to div=1 while locked.
    wr(1, 1, 1'b0);
    chk("wr1_lockfall", bus.LOCK,     1'b0);
    chk("wr1_busy",     bus.CFG_BUSY, 3'b010);
    wait_for("busy1", 0, 1, 10, n);
    wait_for("relock", 2, 0, 200, n);
    chk("relock_cycles", n, 64);
    wait_for("en1", 1, 1, 10, n);
    tick(1); chk("ch1_en_off", bus.CLKEN[1], 1'b0);
    tick(1); chk("ch1_en_on",  bus.CLKEN[1], 1'b1);

    // Two writes to ch0 inside one period: last one wins.
    wait_for("en0", 1, 0, 10, n);
    wr(0, 7, 1'b0);
    wr(0, 2, 1'b0);
    chk("lw_busy_a", bus.CFG_BUSY[0], 1'b1);
    tick(1); chk("lw_busy_b", bus.CFG_BUSY[0], 1'b1);
    tick(1); chk("lw_busy_c", bus.CFG_BUSY[0], 1'b0);
             chk("lw_en_a",   bus.CLKEN[0],    1'b1);
    tick(1); chk("lw_en_b",   bus.CLKEN[0],    1'b0);
    tick(1); chk("lw_en_c",   bus.CLKEN[0],    1'b0);
    tick(1); chk("lw_en_d",   bus.CLKEN[0],    1'b1);

    // Bypass on ch2, then div=0 without bypass.
    wr(2, 0, 1'b1);
    wait_for("busy2", 0, 2, 10, n);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      chk("byp_en", bus.CLKEN[2], 1'b1);
      tick(1);
    end
    wr(2, 0, 1'b0);
    chk("div0_busy_set", bus.CFG_BUSY[2], 1'b1);
    tick(1); chk("div0_busy_clr", bus.CFG_BUSY[2], 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("div0_en", bus.CLKEN[2], 1'b1);
      tick(1);
    end

    // Reset while ch0 busy: immediate clear, no residual apply.
    wr(0, 5, 1'b0);
    chk("pre_rst_busy", bus.CFG_BUSY[0], 1'b1);
    #2 RESETN = 1'b0;
    #1;
    chk("mid_rst_clken",  bus.CLKEN,    3'b000);
    chk("mid_rst_clkout", bus.CLKOUT,   3'b000);
    chk("mid_rst_busy",   bus.CFG_BUSY, 3'b000);
    chk("mid_rst_lock",   bus.LOCK,     1'b0);
    tick(2);
    RESETN = 1'b1;
    tick(3); chk("rel_en_c3",   bus.CLKEN,    3'b000);
             chk("rel_busy_c3", bus.CFG_BUSY, 3'b000);
    tick(1); chk("rel_en_c4",   bus.CLKEN,    3'b111);
    tick(4); chk("rel_en_c8",   bus.CLKEN,    3'b111);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mss_ccc_divgen.md
MSS_CCC_DIVGEN -- requirements
Module: mss_ccc_divgen

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning the number of divider channels (legal range 1..4).
REQ-002 SHALL have parameter DIVW, default 5, meaning the width of the divide-code field.
REQ-003 SHALL have parameter DEF_DIV, default 3, meaning the divide code loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYC, default 64, meaning the number of stable cycles required before LOCK asserts (legal range 2..65535).
REQ-005 SHALL have port CLKA, input, 1 bit: single source clock; all logic on its rising edge.
REQ-006 SHALL have port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port CFG_WE, input, 1 bit: configuration write strobe.
REQ-008 SHALL have port CFG_CH, input, 2 bits: target channel index.
REQ-009 SHALL have port CFG_DIV, input, DIVW bits: divide code D; channel period is D+1 cycles.
REQ-010 SHALL have port CFG_BYPASS, input, 1 bit: bypass request for the target channel.
REQ-011 SHALL have port CFG_ERR, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-012 SHALL have port CFG_BUSY, output, NCH bits: per-channel flag meaning a configuration is pending.
REQ-013 SHALL have port CLKEN, output, NCH bits: per-channel one-cycle enable strobe.
REQ-014 SHALL have port CLKOUT, output, NCH bits: per-channel registered divided clock.
REQ-015 SHALL have port LOCK, output, 1 bit: all channels stable for LOCK_CYC cycles.

Function
REQ-016 Each channel SHALL hold an active config {div, bypass}, a pending config, a pending-valid flag and a DIVW-bit down-counter.
REQ-017 When not in bypass, the counter SHALL load the active div when it reaches 0 and decrement otherwise; the terminal count is the cycle in which the counter equals 0.
REQ-018 CLKEN[i] SHALL be high, registered, exactly in the cycle after each terminal count, giving one strobe every div+1 cycles; div=0 SHALL give CLKEN held high.
REQ-019 CLKOUT[i] SHALL toggle on each terminal count, giving period 2*(div+1).
REQ-020 In bypass, CLKEN[i] SHALL be held 1, CLKOUT[i] SHALL toggle every cycle, and the counter SHALL be held at 0.
REQ-021 A write with CFG_WE=1 and CFG_CH<NCH SHALL be accepted: {CFG_DIV, CFG_BYPASS} goes into the pending slot and CFG_BUSY[CFG_CH] is set the next cycle.
REQ-022 A write with CFG_CH>=NCH SHALL be ignored, with CFG_ERR pulsed for one cycle in the next cycle.
REQ-023 A pending config SHALL be applied only at the channel's next terminal count (glitch-free): active is updated, the counter reloads the new div, and CFG_BUSY clears in the same cycle; in bypass the pending config applies on the next cycle.
REQ-024 A second write to a channel that is still busy SHALL overwrite the pending slot (last write wins), with no error.
REQ-025 A write arriving in the same cycle as an apply SHALL become the new pending config, and CFG_BUSY SHALL remain 1.
REQ-026 The lock FSM SHALL have states WAIT, COUNT and LOCKED, with a 16-bit stable counter.
REQ-027 The lock FSM SHALL move WAIT->COUNT in the first cycle after reset release.
REQ-028 In COUNT, the stable counter SHALL increment only while CFG_BUSY is all-zero and no write is accepted; otherwise it SHALL clear.
REQ-029 The lock FSM SHALL move COUNT->LOCKED when the stable counter reaches LOCK_CYC-1.
REQ-030 Any accepted write SHALL force LOCKED->COUNT with the counter cleared, and LOCK SHALL fall in the next cycle.
REQ-031 LOCK SHALL be 1 only in LOCKED.
REQ-032 A rejected write SHALL not affect the lock FSM.

Reset
REQ-033 On RESETN low, all state SHALL clear asynchronously: active div=DEF_DIV, bypass=0, counters=DEF_DIV, pending-valid=0, CLKEN=0, CLKOUT=0, CFG_BUSY=0, CFG_ERR=0, LOCK=0, FSM=WAIT.
REQ-034 Reset asserted mid-operation SHALL discard pending configs and drop LOCK immediately.
REQ-035 After reset release, the first CLKEN SHALL occur DEF_DIV+1 cycles later.

Verification
REQ-036 Reset release with defaults -> CLKEN strobes every 4 cycles on all channels, CLKOUT period 8, LOCK rises at cycle 65 after release.
REQ-037 While LOCKED, write ch1 div=1 -> LOCK falls next cycle, CFG_BUSY[1] high until ch1's next terminal count, then ch1 strobes every 2 cycles; LOCK returns 64 stable cycles later.
REQ-038 Write CFG_CH=3 with NCH=3 -> CFG_ERR one-cycle pulse, no CFG_BUSY change, LOCK unaffected.
REQ-039 Two writes to ch0 (div=7, then div=2) before its terminal count -> only div=2 applied, a single busy period.
REQ-040 Write ch2 bypass=1 -> CLKEN[2] constant 1, CLKOUT[2] toggles every cycle; a later write with bypass=0, div=0 -> CLKEN[2] stays 1, CLKOUT[2] still toggles every cycle.
REQ-041 Assert RESETN low while ch0 is busy -> all outputs at reset values within the same cycle, no residual apply after release.
